// File: rtl/prepare_log_wr_eng.sv
// prepare_log_wr_eng: moves an accepted Prepare payload from the NoC stream into log memory,
// dropping the header so payload byte 0 lands at the MSB of log line 0.
module prepare_log_wr_eng #(
    parameter int NOC_DATA_W = 512,
    parameter int NOC_BYTES  = NOC_DATA_W / 8,
    parameter int HDR_BYTES  = 32,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_log_start_val,
    output logic                  log_ctrl_start_rdy,
    input  logic [LEN_W-1:0]      ctrl_log_payload_len,
    input  logic                  manage_log_data_val,
    input  logic [NOC_DATA_W-1:0] manage_log_data,
    input  logic                  manage_log_data_last,
    output logic                  log_manage_data_rdy,
    output logic                  log_data_mem_wr_val,
    output logic [NOC_DATA_W-1:0] log_data_mem_wr_data,
    input  logic                  log_data_mem_wr_rdy,
    output logic                  log_ctrl_datap_incr_wr_addr,
    output logic                  log_ctrl_wr_done,
    output logic                  log_ctrl_len_err
);
    localparam int CNT_W   = LEN_W + 1;
    localparam int HDR_W   = HDR_BYTES * 8;
    localparam int CARRY_W = NOC_DATA_W - HDR_W;
    localparam int LB_W    = $clog2(NOC_BYTES);
    localparam logic [CNT_W-1:0] NB_C  = CNT_W'(NOC_BYTES);
    localparam logic [CNT_W-1:0] HDR_C = CNT_W'(HDR_BYTES);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    // IDLE wait start | FIRST line 0 into carry | STREAM realign | DRAIN flush carry | DONE pulse
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      in_lines_q, in_lines_d;
    logic [CNT_W-1:0]      out_lines_q, out_lines_d;
    logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic [CARRY_W-1:0]    carry_q, carry_d;
    logic                  wr_val_q, wr_val_d;
    logic [NOC_DATA_W-1:0] wr_data_q, wr_data_d;
    logic                  err_q, err_d;

    logic [CNT_W-1:0]      len_ext, sum_len, in_lines_calc, out_lines_calc;
    logic                  in_more, out_free, in_rdy, in_acc, wr_acc, load;
    logic [NOC_DATA_W-1:0] load_line, load_masked;

    always_comb begin
        len_ext        = CNT_W'(ctrl_log_payload_len);
        sum_len        = len_ext + HDR_C;
        in_lines_calc  = (sum_len >> LB_W) + CNT_W'(|sum_len[LB_W-1:0]);
        out_lines_calc = (len_ext >> LB_W) + CNT_W'(|len_ext[LB_W-1:0]);
    end

    always_comb begin
        in_more  = in_cnt_q < in_lines_q;
        out_free = ~wr_val_q | log_data_mem_wr_rdy;
        in_rdy   = in_more & ((state_q == ST_FIRST) | ((state_q == ST_STREAM) & out_free));
        in_acc   = in_rdy & manage_log_data_val;
        wr_acc   = wr_val_q & log_data_mem_wr_rdy;
    end

    always_comb begin
        state_d     = state_q;
        in_lines_d  = in_lines_q;
        out_lines_d = out_lines_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        rem_d       = rem_q;
        carry_d     = carry_q;
        wr_val_d    = wr_val_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;
        load        = 1'b0;
        load_line   = '0;
        load_masked = '0;

        if (wr_acc) begin
            wr_val_d = 1'b0;
        end

        // last must coincide exactly with the final counted line; flow follows the counts
        if (in_acc) begin
            in_cnt_d = in_cnt_q + ONE_C;
            carry_d  = manage_log_data[CARRY_W-1:0];
            if (manage_log_data_last != (in_cnt_q == in_lines_q - ONE_C)) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_log_start_val) begin
                    in_lines_d  = in_lines_calc;
                    out_lines_d = out_lines_calc;
                    rem_d       = len_ext;
                    in_cnt_d    = '0;
                    out_cnt_d   = '0;
                    err_d       = 1'b0;
                    state_d     = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (in_acc) begin
                    if (in_lines_q != ONE_C) begin
                        state_d = ST_STREAM;
                    end else if (out_lines_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_STREAM: begin
                if (in_acc) begin
                    load      = 1'b1;
                    load_line = {carry_q, manage_log_data[NOC_DATA_W-1 -: HDR_W]};
                    if ((in_cnt_q == in_lines_q - ONE_C) && (out_lines_q == in_lines_q)) begin
                        state_d = ST_DRAIN;
                    end
                end else if (!in_more && wr_acc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (out_cnt_q != out_lines_q) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_line = {carry_q, {HDR_W{1'b0}}};
                    end
                end else if (wr_acc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        for (int b = 0; b < NOC_BYTES; b++) begin
            if (CNT_W'(b) < rem_q) begin
                load_masked[NOC_DATA_W-1-8*b -: 8] = load_line[NOC_DATA_W-1-8*b -: 8];
            end
        end

        if (load) begin
            wr_val_d  = 1'b1;
            wr_data_d = load_masked;
            out_cnt_d = out_cnt_q + ONE_C;
            rem_d     = (rem_q > NB_C) ? rem_q - NB_C : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_lines_q  <= '0;
            out_lines_q <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            rem_q       <= '0;
            carry_q     <= '0;
            wr_val_q    <= 1'b0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_lines_q  <= in_lines_d;
            out_lines_q <= out_lines_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            rem_q       <= rem_d;
            carry_q     <= carry_d;
            wr_val_q    <= wr_val_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
        end
    end

    assign log_ctrl_start_rdy          = (state_q == ST_IDLE);
    assign log_manage_data_rdy         = in_rdy;
    assign log_data_mem_wr_val         = wr_val_q;
    assign log_data_mem_wr_data        = wr_data_q;
    assign log_ctrl_datap_incr_wr_addr = wr_acc;
    assign log_ctrl_wr_done            = (state_q == ST_DONE);
    assign log_ctrl_len_err            = err_q;

endmodule

// File: doc/prepare_log_wr_eng.md
# prepare_log_wr_eng

Streams the payload of an accepted Prepare message from the manage stage's NoC data bus into the log data memory. The payload is realigned so the first payload byte lands at bit `NOC_DATA_W-1` of log line 0. It sits between the manage stage and the log data memory, beside the prepare datapath/controller. It issues one `log_ctrl_datap_incr_wr_addr` pulse per line written, so the datapath's `wr_addr_reg` tracks the write address, and one done pulse per entry.

## Interface
Parameters:
- `NOC_DATA_W`, 512, NoC and log line width in bits (log line = NoC line)
- `NOC_BYTES`, `NOC_DATA_W/8`, bytes per line
- `HDR_BYTES`, 32, Prepare header bytes at the top of NoC line 0; must satisfy 0 < `HDR_BYTES` < `NOC_BYTES`
- `LEN_W`, 16, payload byte-length width

Ports (name, direction, width, meaning):
- `clk`, in, 1, sole clock
- `rst_n`, in, 1, reset; synchronous, active-low
- `ctrl_log_start_val`, in, 1, start request
- `log_ctrl_start_rdy`, out, 1, high only in IDLE
- `ctrl_log_payload_len`, in, `LEN_W`, payload bytes (`data_length` − `HDR_BYTES`)
- `manage_log_data_val`, in, 1, NoC line valid
- `manage_log_data`, in, `NOC_DATA_W`, NoC line, byte 0 at MSB
- `manage_log_data_last`, in, 1, final NoC line of message
- `log_manage_data_rdy`, out, 1, line accepted when val&rdy
- `log_data_mem_wr_val`, out, 1, write valid
- `log_data_mem_wr_data`, out, `NOC_DATA_W`, realigned payload line
- `log_data_mem_wr_rdy`, in, 1, memory accepts
- `log_ctrl_datap_incr_wr_addr`, out, 1, equals `log_data_mem_wr_val & log_data_mem_wr_rdy`
- `log_ctrl_wr_done`, out, 1, one-cycle pulse at entry completion
- `log_ctrl_len_err`, out, 1, sticky; set on last/length mismatch; cleared on start

## Operation
- On start handshake, latch:
  - `in_lines = ceil((len+HDR_BYTES)/NOC_BYTES)`
  - `out_lines = ceil(len/NOC_BYTES)`
  - `len`
- Counters are `LEN_W+1` bits wide. Both ceilings use the low-bits-nonzero test with no divider.
- States: IDLE → FIRST → STREAM → (DRAIN) → DONE → IDLE.
- **FIRST:** accept NoC line 0. Store its low `(NOC_BYTES-HDR_BYTES)` bytes in carry register `carry`. No write is issued.
  - `in_lines==1` and `out_lines==0` → DONE.
  - `in_lines==1` and `out_lines==1` → DRAIN.
  - Otherwise → STREAM.
- **STREAM:** each accepted line `cur` loads the output register with `{carry, cur[NOC_DATA_W-1 -: HDR_BYTES*8]}` and updates `carry` from the low bytes of `cur`.
  - After input line `in_lines-1` is accepted: go to DRAIN if `out_lines == in_lines`, else wait for the output register to empty, then DONE.
- **DRAIN:** load output `{carry, HDR_BYTES*8 zeros}` once. When it is written, go to DONE.
- Every output line has the bytes at index ≥ remaining payload bytes forced to zero. The remaining byte count decrements by `NOC_BYTES` per line.
- `manage_log_data_last` is checked on every accepted line. Set `log_ctrl_len_err` if either holds:
  - last is high before input line `in_lines-1`;
  - last is low on that line.
  The block never hangs on this: counts rule, and flow continues by count.
- **DONE:** assert `log_ctrl_wr_done` for one cycle, then go to IDLE.

## Timing
- Reset (`rst_n`=0 at a clk edge):
  - state returns to IDLE;
  - all counters are cleared, `carry` is cleared, and the output register is invalidated;
  - outputs go to `log_ctrl_start_rdy`=1, all other outputs 0, `log_ctrl_len_err`=0.
  - Reset mid-entry abandons the entry with no done pulse. The stream is not drained; the controller reissues.
- Output register is a one-entry skid: `log_manage_data_rdy` = (state∈{FIRST,STREAM} input remaining) & (FIRST | ~`log_data_mem_wr_val` | `log_data_mem_wr_rdy`).
- There is no combinational path from `manage_log_data_val` to `log_data_mem_wr_val`. Write data appears the cycle after the input handshake.
- `log_data_mem_wr_val` holds, and `log_data_mem_wr_data` stays stable, until rdy.
- Throughput is one line per cycle with both sides ready.
- Latency:
  - start→first write is 2 cycles minimum (FIRST accept, then STREAM accept registers the output);
  - last write handshake → `log_ctrl_wr_done` is the next cycle;
  - the next start is accepted one cycle after done.
- `len` = 0 completes with zero writes. `len` at the maximum `2^LEN_W-1` needs no counter overflow (`LEN_W+1` bits).

## Test plan
- `len`=0, one NoC line with last=1 → no writes, done 2 cycles after start, err=0.
- `len`=100 (`NOC_BYTES`=64, `HDR_BYTES`=32), 3 NoC lines with incrementing bytes 0..131 → 2 writes: bytes 32..95, then bytes 96..131 plus 28 zero bytes; 2 incr pulses; done.
- `len`=20, 1 line → DRAIN path: 1 write of bytes 32..51 plus 44 zeros; done.
- `len`=90, 2 lines, `log_data_mem_wr_rdy` toggling 1-0-0-1 → 2 writes with data stable while stalled; `log_manage_data_rdy` low while the output register is full and unwritten; no line lost or duplicated.
- `len`=100 with last asserted on line 1 → err=1, 3 lines still consumed, done pulses; the next start clears err.
- `rst_n` low for 1 cycle after the first write of a `len`=100 entry → all outputs at reset values the next cycle; a fresh `len`=20 entry then completes correctly.
